// File: rtl/fgpio_ext.sv
// Fast-GPIO custom-instruction extension: executes custom-0 funct7 commands against up to
// 32 pads, with synchronised inputs, sticky rising-edge flags, timed pulse and wait-for-match.
module fgpio_ext #(
  parameter int unsigned GPIO_NUM    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WAIT_TMO    = 1000
) (
  input  logic                clk_neg_i,
  input  logic                rst_ni,
  input  logic                fgpio_req,
  input  logic [6:0]          fgpio_funct7,
  input  logic [31:0]         fgpio_rs1_val,
  input  logic [31:0]         fgpio_rs2_val,
  output logic                fgpio_ack,
  output logic                fgpio_error,
  output logic [31:0]         fgpio_rd_val,
  output logic [GPIO_NUM-1:0] gpio_dir,
  input  logic [GPIO_NUM-1:0] gpio_in_val,
  output logic [GPIO_NUM-1:0] gpio_out_val
);

  localparam logic [6:0] F_RD_ALL  = 7'h00;
  localparam logic [6:0] F_RD_BIT  = 7'h01;
  localparam logic [6:0] F_RD_EDGE = 7'h02;
  localparam logic [6:0] F_SET_DIR = 7'h10;
  localparam logic [6:0] F_WR_MASK = 7'h40;
  localparam logic [6:0] F_SET     = 7'h41;
  localparam logic [6:0] F_CLR     = 7'h42;
  localparam logic [6:0] F_TOG     = 7'h43;
  localparam logic [6:0] F_PULSE   = 7'h50;
  localparam logic [6:0] F_WAIT    = 7'h51;

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT} state_e;

  state_e              r_state;
  logic [GPIO_NUM-1:0] r_sync [SYNC_STAGES];
  logic [GPIO_NUM-1:0] r_in_prev;
  logic [GPIO_NUM-1:0] r_flags;
  logic [GPIO_NUM-1:0] r_dir;
  logic [GPIO_NUM-1:0] r_out;
  logic [GPIO_NUM-1:0] r_mask;
  logic [GPIO_NUM-1:0] r_pat;
  logic [CNT_W-1:0]    r_cnt;

  state_e              w_state_nx;
  logic [GPIO_NUM-1:0] w_in_s;
  logic [GPIO_NUM-1:0] w_m1;
  logic [GPIO_NUM-1:0] w_m2;
  logic [GPIO_NUM-1:0] w_rise;
  logic [GPIO_NUM-1:0] w_flag_clr;
  logic [GPIO_NUM-1:0] w_dir_nx;
  logic [GPIO_NUM-1:0] w_out_nx;
  logic [GPIO_NUM-1:0] w_mask_nx;
  logic [GPIO_NUM-1:0] w_pat_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [CNT_W-1:0]    w_n;
  logic [31:0]         w_in_ext;
  logic [31:0]         w_rd;
  logic [4:0]          w_idx;
  logic                w_idx_ok;
  logic                w_match;
  logic                w_ack;
  logic                w_err;
  logic                w_unused;

  assign w_in_s   = r_sync[SYNC_STAGES-1];
  assign w_in_ext = 32'(w_in_s);
  assign w_m1     = fgpio_rs1_val[GPIO_NUM-1:0];
  assign w_m2     = fgpio_rs2_val[GPIO_NUM-1:0];
  assign w_rise   = w_in_s & ~r_in_prev;
  assign w_idx    = fgpio_rs1_val[4:0];
  assign w_idx_ok = ({27'd0, w_idx} < 32'(GPIO_NUM));
  // A zero pulse length still produces a one-cycle pulse.
  assign w_n      = (fgpio_rs2_val[CNT_W-1:0] == '0) ? CNT_W'(1) : fgpio_rs2_val[CNT_W-1:0];
  assign w_match  = ((w_in_s ^ r_pat) & r_mask) == '0;
  assign w_unused = ^{fgpio_rs1_val, fgpio_rs2_val};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_out_nx   = r_out;
    w_mask_nx  = r_mask;
    w_pat_nx   = r_pat;
    w_cnt_nx   = r_cnt;
    w_flag_clr = '0;
    w_ack      = 1'b0;
    w_err      = 1'b0;
    w_rd       = '0;
    case (r_state)
      ST_IDLE: begin
        if (fgpio_req) begin
          case (fgpio_funct7)
            F_RD_ALL: begin
              w_ack = 1'b1;
              w_rd  = w_in_ext;
            end
            F_RD_BIT: begin
              w_ack = 1'b1;
              if (w_idx_ok) w_rd = {31'd0, w_in_ext[w_idx]};
              else          w_err = 1'b1;
            end
            F_RD_EDGE: begin
              w_ack      = 1'b1;
              w_rd       = 32'(r_flags);
              w_flag_clr = w_m1;
            end
            F_SET_DIR: begin
              w_ack    = 1'b1;
              w_dir_nx = w_m1;
            end
            F_WR_MASK: begin
              w_ack    = 1'b1;
              w_out_nx = (r_out & ~w_m2) | (w_m1 & w_m2);
              w_dir_nx = r_dir | w_m2;
            end
            F_SET: begin
              w_ack    = 1'b1;
              w_out_nx = r_out | w_m1;
            end
            F_CLR: begin
              w_ack    = 1'b1;
              w_out_nx = r_out & ~w_m1;
            end
            F_TOG: begin
              w_ack    = 1'b1;
              w_out_nx = r_out ^ w_m1;
            end
            F_PULSE: begin
              w_out_nx   = r_out ^ w_m1;
              w_mask_nx  = w_m1;
              w_cnt_nx   = w_n;
              w_state_nx = ST_PULSE;
            end
            F_WAIT: begin
              w_mask_nx  = w_m1;
              w_pat_nx   = w_m2;
              w_cnt_nx   = '0;
              w_state_nx = ST_WAIT;
            end
            default: begin
              w_ack = 1'b1;
              w_err = 1'b1;
            end
          endcase
        end
      end
      ST_PULSE: begin
        if (r_cnt == CNT_W'(1)) begin
          w_ack      = 1'b1;
          w_out_nx   = r_out ^ r_mask;
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (w_match) begin
          w_ack      = 1'b1;
          w_rd       = 32'(r_cnt);
          w_state_nx = ST_IDLE;
        end else if (r_cnt == CNT_W'(WAIT_TMO - 1)) begin
          w_ack      = 1'b1;
          w_err      = 1'b1;
          w_rd       = 32'(WAIT_TMO);
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_neg_i) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_in_prev <= '0;
      r_flags   <= '0;
      r_dir     <= '0;
      r_out     <= '0;
      r_mask    <= '0;
      r_pat     <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_in_prev <= w_in_s;
      // A rise in the same cycle as a clear keeps the flag set.
      r_flags   <= (r_flags & ~w_flag_clr) | w_rise;
      r_dir     <= w_dir_nx;
      r_out     <= w_out_nx;
      r_mask    <= w_mask_nx;
      r_pat     <= w_pat_nx;
      r_cnt     <= w_cnt_nx;
      r_sync[0] <= gpio_in_val;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Command outputs are combinational and held at zero while reset is asserted.
  assign fgpio_ack    = rst_ni & w_ack;
  assign fgpio_error  = rst_ni & w_err;
  assign fgpio_rd_val = rst_ni ? w_rd : 32'd0;
  assign gpio_dir     = r_dir;
  assign gpio_out_val = r_out;

endmodule

// File: tb/tb_fgpio_ext.sv
// Self-checking bench for fgpio_ext: directed scenarios plus random commands, every cycle
// compared against a timestamp-based reference model of the command set.
module tb_fgpio_ext;

  localparam int GN  = 8;
  localparam int SS  = 2;
  localparam int CW  = 16;
  localparam int TMO = 1000;

  localparam logic [6:0] C_RD_ALL  = 7'h00;
  localparam logic [6:0] C_RD_BIT  = 7'h01;
  localparam logic [6:0] C_RD_EDGE = 7'h02;
  localparam logic [6:0] C_SET_DIR = 7'h10;
  localparam logic [6:0] C_WR_MASK = 7'h40;
  localparam logic [6:0] C_SET     = 7'h41;
  localparam logic [6:0] C_CLR     = 7'h42;
  localparam logic [6:0] C_TOG     = 7'h43;
  localparam logic [6:0] C_PULSE   = 7'h50;
  localparam logic [6:0] C_WAIT    = 7'h51;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req;
  logic [6:0]    funct7;
  logic [31:0]   rs1;
  logic [31:0]   rs2;
  logic          ack;
  logic          err;
  logic [31:0]   rd;
  logic [GN-1:0] dir;
  logic [GN-1:0] pin_in;
  logic [GN-1:0] pin_out;

  always #5 clk = ~clk;

  fgpio_ext #(
    .GPIO_NUM   (GN),
    .SYNC_STAGES(SS),
    .CNT_W      (CW),
    .WAIT_TMO   (TMO)
  ) dut (
    .clk_neg_i    (clk),
    .rst_ni       (rst_ni),
    .fgpio_req    (req),
    .fgpio_funct7 (funct7),
    .fgpio_rs1_val(rs1),
    .fgpio_rs2_val(rs2),
    .fgpio_ack    (ack),
    .fgpio_error  (err),
    .fgpio_rd_val (rd),
    .gpio_dir     (dir),
    .gpio_in_val  (pin_in),
    .gpio_out_val (pin_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pad history gives in_s, operations are tracked by accept timestamp.
  int            m_cyc;
  int            m_op;      // 0 idle, 1 pulse, 2 wait
  int            m_t0;
  int            m_n;
  logic [GN-1:0] m_dir, m_out, m_flags, m_prev, m_mask, m_pat;
  logic [GN-1:0] m_hist [SS];
  logic          e_ack, e_err;
  logic [31:0]   e_rd;
  logic          o_ack, o_err;
  logic [31:0]   o_rd;
  int            sched_cyc;
  logic [GN-1:0] sched_val;
  bit            rand_pad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_t0 = 0; m_n = 0;
    m_dir = '0; m_out = '0; m_flags = '0; m_prev = '0; m_mask = '0; m_pat = '0;
    for (int i = 0; i < SS; i++) m_hist[i] = '0;
  endtask

  task automatic model_eval();
    logic [GN-1:0] ins;
    int k;
    int idx;
    ins   = m_hist[0];
    e_ack = 1'b0;
    e_err = 1'b0;
    e_rd  = '0;
    if (rst_ni) begin
      if (m_op == 1) begin
        e_ack = (m_cyc == m_t0 + m_n);
      end else if (m_op == 2) begin
        k = m_cyc - m_t0 - 1;
        if ((ins & m_mask) == (m_pat & m_mask)) begin
          e_ack = 1'b1; e_rd = 32'(k);
        end else if (k == TMO - 1) begin
          e_ack = 1'b1; e_err = 1'b1; e_rd = 32'(TMO);
        end
      end else if (req) begin
        case (funct7)
          C_RD_ALL: begin e_ack = 1'b1; e_rd = 32'(ins); end
          C_RD_BIT: begin
            idx   = int'(rs1[4:0]);
            e_ack = 1'b1;
            if (idx < GN) e_rd = (32'(ins) >> idx) & 32'd1;
            else          e_err = 1'b1;
          end
          C_RD_EDGE: begin e_ack = 1'b1; e_rd = 32'(m_flags); end
          C_SET_DIR, C_WR_MASK, C_SET, C_CLR, C_TOG: e_ack = 1'b1;
          C_PULSE, C_WAIT: e_ack = 1'b0;
          default: begin e_ack = 1'b1; e_err = 1'b1; end
        endcase
      end
    end
  endtask

  task automatic model_update();
    logic [GN-1:0] ins, m1, m2, clr;
    if (!rst_ni) begin
      model_reset();
    end else begin
      ins = m_hist[0];
      m1  = rs1[GN-1:0];
      m2  = rs2[GN-1:0];
      clr = '0;
      if (m_op == 1) begin
        if (e_ack) begin m_out = m_out ^ m_mask; m_op = 0; end
      end else if (m_op == 2) begin
        if (e_ack) m_op = 0;
      end else if (req) begin
        case (funct7)
          C_RD_EDGE: clr = m1;
          C_SET_DIR: m_dir = m1;
          C_WR_MASK: begin m_out = (m_out & ~m2) | (m1 & m2); m_dir = m_dir | m2; end
          C_SET:     m_out = m_out | m1;
          C_CLR:     m_out = m_out & ~m1;
          C_TOG:     m_out = m_out ^ m1;
          C_PULSE: begin
            m_out  = m_out ^ m1;
            m_mask = m1;
            m_n    = (rs2[CW-1:0] == '0) ? 1 : int'(rs2[CW-1:0]);
            m_t0   = m_cyc;
            m_op   = 1;
          end
          C_WAIT: begin m_mask = m1; m_pat = m2; m_t0 = m_cyc; m_op = 2; end
          default: clr = '0;
        endcase
      end
      m_flags = (m_flags & ~clr) | (ins & ~m_prev);
      m_prev  = ins;
      for (int i = 0; i < SS - 1; i++) m_hist[i] = m_hist[i+1];
      m_hist[SS-1] = pin_in;
    end
    m_cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    o_ack = ack;
    o_err = err;
    o_rd  = rd;
    check("ack", 32'(ack), 32'(e_ack));
    check("error", 32'(err), 32'(e_err));
    check("rd_val", rd, e_rd);
    check("gpio_dir", 32'(dir), 32'(m_dir));
    check("gpio_out", 32'(pin_out), 32'(m_out));
    @(posedge clk);
    model_update();
    #1;
    if (m_cyc == sched_cyc) pin_in = sched_val;
    else if (rand_pad && $urandom_range(0, 3) == 0) pin_in = GN'($urandom);
  endtask

  task automatic issue(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int ncyc);
    bit done;
    done   = 1'b0;
    ncyc   = 0;
    req    = 1'b1;
    funct7 = f;
    rs1    = a;
    rs2    = b;
    for (int i = 0; i < TMO + 20 && !done; i++) begin
      step();
      ncyc++;
      if (e_ack) begin
        done = 1'b1;
      end else begin
        funct7 = 7'($urandom);
        rs1    = $urandom;
        rs2    = $urandom;
      end
    end
    req = 1'b0;
    check("ack_within_budget", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nc;
    int acks;
    int lim;
    int sel;
    logic [31:0] r;
    logic [6:0] codes [10];
    codes = '{C_RD_ALL, C_RD_BIT, C_RD_EDGE, C_SET_DIR, C_WR_MASK,
              C_SET, C_CLR, C_TOG, C_PULSE, C_WAIT};

    model_reset();
    m_cyc = 0; sched_cyc = -1; sched_val = '0; rand_pad = 1'b0;
    rst_ni = 1'b0; req = 1'b0; funct7 = '0; rs1 = '0; rs2 = '0; pin_in = '0;
    repeat (3) step();
    check("reset_dir", 32'(dir), 32'd0);
    check("reset_out", 32'(pin_out), 32'd0);
    rst_ni = 1'b1;

    pin_in = GN'(32'hA5);
    repeat (3) step();
    issue(C_RD_ALL, 32'd0, 32'd0, nc);
    check("rd_all_rd", o_rd, 32'h0000_00A5);
    check("rd_all_ack", 32'(o_ack), 32'd1);
    check("rd_all_err", 32'(o_err), 32'd0);
    check("rd_all_latency", 32'(nc), 32'd1);

    issue(C_WR_MASK, 32'hF0, 32'h3C, nc);
    check("wr_mask_out", 32'(pin_out), 32'h30);
    check("wr_mask_dir", 32'(dir), 32'h3C);
    issue(C_SET, 32'h01, 32'd0, nc);
    check("set_out", 32'(pin_out), 32'h31);
    issue(C_CLR, 32'h10, 32'd0, nc);
    check("clr_out", 32'(pin_out), 32'h21);
    issue(C_TOG, 32'hFF, 32'd0, nc);
    check("tog_out", 32'(pin_out), 32'hDE);

    issue(C_CLR, 32'hFF, 32'd0, nc);
    issue(C_PULSE, 32'h01, 32'd3, nc);
    check("pulse3_cycles", 32'(nc), 32'd4);
    check("pulse3_end_out", 32'(pin_out), 32'h00);
    issue(C_PULSE, 32'h01, 32'd0, nc);
    check("pulse0_cycles", 32'(nc), 32'd2);
    issue(C_PULSE, 32'h81, 32'hABCD_0002, nc);
    check("pulse_trunc_cycles", 32'(nc), 32'd3);

    pin_in = '0;
    repeat (SS + 1) step();
    sched_cyc = m_cyc + 10;
    sched_val = GN'(32'h80);
    issue(C_WAIT, 32'h80, 32'h80, nc);
    check("wait_match_rd", o_rd, 32'(10 + SS - 1));
    check("wait_match_err", 32'(o_err), 32'd0);
    sched_cyc = -1;

    pin_in = '0;
    repeat (SS + 1) step();
    issue(C_WAIT, 32'h80, 32'h80, nc);
    check("wait_tmo_rd", o_rd, 32'(TMO));
    check("wait_tmo_err", 32'(o_err), 32'd1);
    check("wait_tmo_cycles", 32'(nc), 32'(TMO + 1));
    issue(C_WAIT, 32'h00, 32'hFF, nc);
    check("wait_mask0_rd", o_rd, 32'd0);
    check("wait_mask0_cycles", 32'(nc), 32'd2);

    repeat (4) step();
    issue(C_RD_EDGE, 32'hFF, 32'd0, nc);
    pin_in = GN'(32'h04);
    repeat (4) step();
    issue(C_RD_EDGE, 32'h04, 32'd0, nc);
    check("edge_bit2_set", o_rd & 32'h4, 32'h4);
    issue(C_RD_EDGE, 32'h00, 32'd0, nc);
    check("edge_bit2_cleared", o_rd & 32'h4, 32'h0);
    pin_in = '0;
    repeat (4) step();
    issue(C_RD_EDGE, 32'hFF, 32'd0, nc);
    pin_in = GN'(32'h04);
    repeat (SS) step();
    issue(C_RD_EDGE, 32'h04, 32'd0, nc);
    check("edge_clear_cycle_pre", o_rd & 32'h4, 32'h0);
    issue(C_RD_EDGE, 32'h00, 32'd0, nc);
    check("edge_set_wins", o_rd & 32'h4, 32'h4);

    issue(C_RD_BIT, 32'd9, 32'd0, nc);
    check("rd_bit_bad_err", 32'(o_err), 32'd1);
    check("rd_bit_bad_rd", o_rd, 32'd0);
    issue(C_RD_BIT, 32'hFFFF_FFE2, 32'd0, nc);
    check("rd_bit2_rd", o_rd, 32'd1);

    issue(7'h7F, $urandom, $urandom, nc);
    check("illegal_ack", 32'(o_ack), 32'd1);
    check("illegal_err", 32'(o_err), 32'd1);
    check("illegal_dir", 32'(dir), 32'h3C);
    check("illegal_out", 32'(pin_out), 32'h00);

    issue(C_SET_DIR, 32'hFF, 32'd0, nc);
    issue(C_SET, 32'h0F, 32'd0, nc);
    req = 1'b1; funct7 = C_PULSE; rs1 = 32'hF0; rs2 = 32'd20;
    repeat (3) step();
    rst_ni = 1'b0; req = 1'b0;
    step();
    check("midrst_ack", 32'(o_ack), 32'd0);
    rst_ni = 1'b1;
    check("midrst_out", 32'(pin_out), 32'h00);
    check("midrst_dir", 32'(dir), 32'h00);
    acks = 0;
    repeat (25) begin
      step();
      acks += int'(o_ack);
    end
    check("midrst_no_late_ack", 32'(acks), 32'd0);

    rand_pad = 1'b1;
    lim = m_cyc + 30000;
    for (int n = 0; n < 300 && m_cyc < lim; n++) begin
      sel = $urandom_range(0, 10);
      r   = $urandom;
      if (sel == 10) begin
        issue(7'($urandom), $urandom, $urandom, nc);
      end else if (codes[sel] == C_PULSE) begin
        issue(C_PULSE, $urandom, (r & 32'hFFFF_0000) | $urandom_range(0, 5), nc);
      end else if (codes[sel] == C_WAIT) begin
        issue(C_WAIT, $urandom & $urandom & $urandom, $urandom, nc);
      end else begin
        issue(codes[sel], $urandom, $urandom, nc);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fgpio_ext.md
Name: fgpio_ext

Overview:
- Parametrised successor of the fast-GPIO custom-instruction unit. Executes custom-0 funct7 commands from the core's extension port against up to 32 pins.
- Adds per-pin direction control, masked set/clear/toggle, input synchronisers with sticky rising-edge flags, and two multi-cycle ops: timed pulse and wait-for-match with timeout.
- Sits between the core execution stage and the pad ring, in the core's negative-edge clock domain.

Parameters:
- GPIO_NUM, 8, number of pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (>=1).
- CNT_W, 16, width of the pulse/timeout counter.
- WAIT_TMO, 1000, wait-for-match timeout in cycles (< 2^CNT_W).

Ports:
- clk_neg_i  in  1  clock, negated core clock; all flops on its rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- fgpio_req  in  1  command request; held high until fgpio_ack.
- fgpio_funct7  in  7  command code.
- fgpio_rs1_val  in  32  operand 1.
- fgpio_rs2_val  in  32  operand 2.
- fgpio_ack  out  1  command complete, single-cycle pulse.
- fgpio_error  out  1  qualifies ack: illegal command, bad index or timeout.
- fgpio_rd_val  out  32  result, valid only with ack, else 0.
- gpio_dir  out  GPIO_NUM  1 = output, registered.
- gpio_in_val  in  GPIO_NUM  asynchronous pad inputs.
- gpio_out_val  out  GPIO_NUM  pad output values, registered.

Behaviour:
- Reset (rst_ni low at a clock edge): dir_q=0, out_q=0, sync chain=0, edge flags=0, counter=0, FSM=IDLE. ack, error and rd_val are 0 while in reset.
- Reset mid-operation: abandon the operation, no ack, pins return to reset values.
- Notation: m = GPIO_NUM-bit slice of an operand; in_s = last synchroniser stage.
- Edge flags: flag[i] set when in_s[i] rises (registered previous value vs current). A set in the same cycle as a clear wins.
- FSM states: IDLE, PULSE, WAIT.
- Single-cycle commands (IDLE, req=1): ack=1 combinationally in the same cycle; register updates at that edge.
  - 0x00 RD_ALL: rd = zero-extended in_s.
  - 0x01 RD_BIT: idx = rs1[4:0]; rd = {31'b0, in_s[idx]}. idx>=GPIO_NUM gives error=1, rd=0.
  - 0x02 RD_EDGE: rd = flags (pre-clear); flags &= ~m(rs1).
  - 0x10 SET_DIR: dir_q = m(rs1).
  - 0x40 WR_MASK: out_q = (out_q & ~m(rs2)) | (m(rs1) & m(rs2)); dir_q |= m(rs2).
  - 0x41 SET: out_q |= m(rs1).
  - 0x42 CLR: out_q &= ~m(rs1).
  - 0x43 TOG: out_q ^= m(rs1).
  - Other codes: ack=1, error=1, no state change.
- 0x50 PULSE (mask=m(rs1), N=rs2[CNT_W-1:0], N=0 treated as 1):
  - Accept cycle T: out_q ^= mask; latch mask; cnt=N; go to PULSE; ack=0.
  - In PULSE: cnt decrements each cycle. When cnt==1: ack=1, out_q ^= latched mask, go to IDLE.
  - Result: pins inverted for exactly N cycles; ack in cycle T+N.
  - Mask bits with dir=0 still toggle out_q but are not driven.
- 0x51 WAIT (mask=m(rs1), pat=m(rs2)):
  - Accept: cnt=0; go to WAIT.
  - Each WAIT cycle: if (in_s & mask)==(pat & mask), ack=1, rd=cnt, go to IDLE. Else if cnt==WAIT_TMO-1, ack=1, error=1, rd=WAIT_TMO, go to IDLE. Else cnt++.
  - mask=0 matches in the first WAIT cycle (rd=0).
- Operands and funct7 are sampled only at accept; changes during PULSE/WAIT are ignored.
- fgpio_req low during PULSE/WAIT is a protocol violation; the operation still completes.
- In the cycle after any ack the FSM is in IDLE and may accept a new command.
- Input latency: pad change is visible in in_s after SYNC_STAGES cycles; edge flag sets one cycle after that.

Test Plan:
- Reset, then RD_ALL with gpio_in_val=0xA5 held 3 cycles -> ack same cycle, rd=0x000000A5, error=0; dir=0, out=0.
- WR_MASK rs1=0xF0, rs2=0x3C -> out=0x30, dir=0x3C. Then SET 0x01 -> 0x31; CLR 0x10 -> 0x21; TOG 0xFF -> 0xDE.
- PULSE rs1=0x01, rs2=3 from out=0x00 -> out=0x01 for exactly 3 cycles, ack in cycle T+3, then out=0x00. Repeat with rs2=0 -> 1-cycle pulse.
- WAIT rs1=0x80, rs2=0x80, pin 7 raised 10 cycles after accept -> ack, error=0, rd=10+SYNC_STAGES-1. With pin held low -> ack, error=1, rd=WAIT_TMO.
- Pin 2 rises, then RD_EDGE rs1=0x04 -> rd bit2=1, flag cleared. A new rise in the clear cycle leaves the flag=1. RD_BIT idx=9 with GPIO_NUM=8 -> error=1.
- Assert reset mid-PULSE -> out=0, dir=0, no ack. funct7=0x7F -> ack=1, error=1, registers unchanged.
